// File: rtl/config_shadow_store.sv
// Double-buffered configuration store: a serial shift register feeds a shadow register on a validated commit.
// Optional even-parity frame check is enabled by defining CONFIG_PARITY_EN.
module config_shadow_store #(
  parameter int NumFields  = 3,
  parameter int FieldWidth = 6,
  parameter logic [NumFields*FieldWidth-1:0] ResetValue = '0
) (
  input  logic                             clk,
  input  logic                             resetN,
  input  logic                             serialEn,
  input  logic                             serialIn,
  output logic                             serialOut,
  input  logic                             commit,
  output logic [NumFields*FieldWidth-1:0]  fields,
  output logic                             configValid,
  output logic                             updated,
  output logic                             commitError
);

  localparam int DataBits = NumFields * FieldWidth;
`ifdef CONFIG_PARITY_EN
  localparam int FrameBits = DataBits + 1;
`else
  localparam int FrameBits = DataBits;
`endif
  localparam int CntW = $clog2(FrameBits + 2);
  localparam logic [CntW-1:0] CntFrame = CntW'(FrameBits);
  localparam logic [CntW-1:0] CntSat   = CntW'(FrameBits + 1);

  // state    | meaning
  // IDLE     | no bits shifted since reset or last commit
  // LOADING  | 1..FrameBits bits shifted; commit valid only at exactly FrameBits
  // OVERRUN  | more than FrameBits bits shifted; any commit is rejected
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_OVERRUN = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [FrameBits-1:0]   shift_q, shift_d;
  logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DataBits-1:0]    fields_q, fields_d;
  logic                   cfg_valid_q, cfg_valid_d;
  logic                   updated_q, updated_d;
  logic                   commit_err_q, commit_err_d;

  logic [DataBits-1:0]    frame_data;
  logic                   parity_ok;
  logic                   frame_exact;
  logic                   accept;
  logic                   reject;

`ifdef CONFIG_PARITY_EN
  // Parity bit is the last bit shifted in, so it sits at the LSB.
  assign frame_data = shift_q[FrameBits-1:1];
  assign parity_ok  = ~(^shift_q);
`else
  assign frame_data = shift_q;
  assign parity_ok  = 1'b1;
`endif

  // Shift register and bit counter
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (serialEn) begin
      shift_d = {shift_q[FrameBits-2:0], serialIn};
      if (bit_cnt_q != CntSat) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
    // Commit clears the count but keeps the shift data for the daisy chain.
    if (commit) begin
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (commit) begin
      state_d = ST_IDLE;
    end else if (serialEn) begin
      case (state_q)
        ST_IDLE:    state_d = ST_LOADING;
        ST_LOADING: if (bit_cnt_q == CntFrame) state_d = ST_OVERRUN;
        ST_OVERRUN: state_d = ST_OVERRUN;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs / commit decision
  always_comb begin
    frame_exact  = (state_q == ST_LOADING) && (bit_cnt_q == CntFrame);
    accept       = commit && !serialEn && frame_exact && parity_ok;
    reject       = commit && !accept;
    fields_d     = accept ? frame_data : fields_q;
    cfg_valid_d  = cfg_valid_q | accept;
    updated_d    = accept;
    commit_err_d = reject;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      fields_q     <= ResetValue;
      cfg_valid_q  <= 1'b0;
      updated_q    <= 1'b0;
      commit_err_q <= 1'b0;
    end else begin
      fields_q     <= fields_d;
      cfg_valid_q  <= cfg_valid_d;
      updated_q    <= updated_d;
      commit_err_q <= commit_err_d;
    end
  end

  assign serialOut   = shift_q[FrameBits-1];
  assign fields      = fields_q;
  assign configValid = cfg_valid_q;
  assign updated     = updated_q;
  assign commitError = commit_err_q;

endmodule

// File: tb/tb_config_shadow_store.sv
// Directed bench for config_shadow_store; frame length follows CONFIG_PARITY_EN.
module tb_config_shadow_store;

  localparam int DB = 18;
`ifdef CONFIG_PARITY_EN
  localparam int FB = DB + 1;
`else
  localparam int FB = DB;
`endif

  logic          clk = 1'b0;
  logic          resetN, serialEn, serialIn, commit;
  logic          serialOut, configValid, updated, commitError;
  logic [DB-1:0] fields;

  int errors = 0;
  int checks = 0;

  logic [DB-1:0] fa, fc, fd, fe, ff;

  config_shadow_store dut (
    .clk(clk), .resetN(resetN), .serialEn(serialEn), .serialIn(serialIn),
    .serialOut(serialOut), .commit(commit), .fields(fields),
    .configValid(configValid), .updated(updated), .commitError(commitError)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic shift_raw(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      serialEn = 1'b1;
      serialIn = val[i];
      tick();
    end
    serialEn = 1'b0;
    serialIn = 1'b0;
  endtask

  // Full frame: data MSB first, then (parity builds) the even-parity bit, optionally corrupted.
  task automatic shift_frame(input logic [DB-1:0] d, input logic bad_par);
    shift_raw({14'd0, d}, DB);
`ifdef CONFIG_PARITY_EN
    shift_raw({31'd0, (^d) ^ bad_par}, 1);
`else
    if (bad_par) shift_raw(32'd0, 0);
`endif
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  initial begin
    fa = {6'h2A, 6'h15, 6'h3F};
    fc = {6'h01, 6'h22, 6'h33};
    fd = {6'h0C, 6'h3A, 6'h05};
    fe = {6'h11, 6'h2B, 6'h1E};
    ff = {6'h3C, 6'h00, 6'h17};
    resetN = 1'b0; serialEn = 1'b0; serialIn = 1'b0; commit = 1'b0;
    tick(); tick();
    resetN = 1'b1;
    repeat (5) tick();
    chk("rst_fields", fields, 0);
    chk("rst_valid", configValid, 0);
    chk("rst_updated", updated, 0);
    chk("rst_err", commitError, 0);
    chk("rst_sout", serialOut, 0);

    // Good frame
    shift_frame(fa, 1'b0);
    chk("a_sout", serialOut, 1);
    chk("a_fields_pre", fields, 0);
    do_commit();
    chk("a_fields", fields, {14'd0, fa});
    chk("a_field0", fields[5:0], 6'h3F);
    chk("a_field2", fields[17:12], 6'h2A);
    chk("a_updated", updated, 1);
    chk("a_valid", configValid, 1);
    chk("a_err", commitError, 0);
    tick();
    chk("a_updated_drop", updated, 0);
    chk("a_valid_sticky", configValid, 1);

    // Short frame
    shift_raw(32'h155AA, FB - 1);
    do_commit();
    chk("short_err", commitError, 1);
    chk("short_updated", updated, 0);
    chk("short_fields", fields, {14'd0, fa});
    tick();
    chk("short_err_drop", commitError, 0);

    // Overrun frame
    shift_raw(32'h7ABCD, FB + 1);
    do_commit();
    chk("over_err", commitError, 1);
    chk("over_fields", fields, {14'd0, fa});
    chk("over_valid", configValid, 1);
    tick();

    // Commit coincident with serialEn: shift still happens, commit rejected
    shift_frame(fc, 1'b0);
    serialEn = 1'b1; serialIn = 1'b0; commit = 1'b1;
    tick();
    serialEn = 1'b0; commit = 1'b0;
    chk("coinc_err", commitError, 1);
    chk("coinc_fields", fields, {14'd0, fa});
`ifdef CONFIG_PARITY_EN
    chk("coinc_sout", serialOut, fc[DB-2]);
`else
    chk("coinc_sout", serialOut, fc[DB-2]);
`endif
    tick();
    // Count restarted at 0, so a fresh full frame is accepted
    shift_frame(fd, 1'b0);
    do_commit();
    chk("d_updated", updated, 1);
    chk("d_fields", fields, {14'd0, fd});
    chk("d_err", commitError, 0);
    tick();

    // Commit held two cycles: first accepted, second rejected
    shift_frame(fe, 1'b0);
    commit = 1'b1;
    tick();
    chk("hold1_updated", updated, 1);
    chk("hold1_fields", fields, {14'd0, fe});
    tick();
    commit = 1'b0;
    chk("hold2_err", commitError, 1);
    chk("hold2_updated", updated, 0);
    chk("hold2_fields", fields, {14'd0, fe});
    tick();

`ifdef CONFIG_PARITY_EN
    shift_frame(fa, 1'b1);
    do_commit();
    chk("par_bad_err", commitError, 1);
    chk("par_bad_fields", fields, {14'd0, fe});
    tick();
    shift_frame(fc, 1'b0);
    do_commit();
    chk("par_ok_updated", updated, 1);
    chk("par_ok_fields", fields, {14'd0, fc});
    tick();
`endif

    // Reset mid-load
    shift_raw(32'h3FF, 10);
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    chk("rst2_fields", fields, 0);
    chk("rst2_valid", configValid, 0);
    chk("rst2_sout", serialOut, 0);
    shift_frame(ff, 1'b0);
    do_commit();
    chk("f_updated", updated, 1);
    chk("f_fields", fields, {14'd0, ff});
    chk("f_valid", configValid, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
